// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID pipeline register of the pipelined RV32I core.
//
// Owns the fetch PC and a single-outstanding req/ack instruction-memory port.
// A one-entry hold buffer catches a word that returns while the pipe is stalled.
// A redirect that lands on a pending fetch lets that fetch complete and drops its data.
//
// State table
//   state     | meaning
//   S_REQ     | request PCF (req low only while StallF=1 with nothing pending)
//   S_HOLD    | fetched word parked in hold buffer, req=0, waiting for stalls to clear
//   S_DISCARD | req held on stale address until ack; that data is dropped
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   StallF, StallD, FlushD          hazard-control inputs
//   PcSrcE, JalrE                   EX-stage redirect (JalrE wins if both are set)
//   PCTargetE, ALUResultE           branch/jal target, jalr target (LSBs cleared here)
//   imem_req, imem_addr             fetch request / word address
//   imem_ack, imem_rdata            accept strobe / instruction word (valid with ack)
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register contents for decode
//   FetchWaitF                      imem_req & ~imem_ack
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PcSrcE,
  input  logic        JalrE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchWaitF
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD} state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] disc_addr_q, disc_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        pend_q, pend_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4d_q, pcplus4d_d;
  logic        valid_d_q, valid_d_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        ack_v;
  logic        word_vld;
  logic [31:0] word;

  always_comb begin
    redirect    = PcSrcE | JalrE;
    redirect_pc = (JalrE ? ALUResultE : PCTargetE) & ALIGN_MASK;

    // Request side. pend_q keeps an already-raised request high through StallF.
    req  = 1'b0;
    addr = pcf_q;
    case (state_q)
      S_REQ:     req = pend_q | ~StallF;
      S_HOLD:    req = 1'b0;
      S_DISCARD: begin
        req  = 1'b1;
        addr = disc_addr_q;
      end
      default:   req = 1'b0;
    endcase
    if (reset) req = 1'b0;
    ack_v = imem_ack & req;

    state_d      = state_q;
    pcf_d        = pcf_q;
    disc_addr_d  = disc_addr_q;
    hold_instr_d = hold_instr_q;
    pend_d       = 1'b0;
    word_vld     = 1'b0;
    word         = imem_rdata;

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pcf_d = redirect_pc;
          if (req && !ack_v) begin
            state_d     = S_DISCARD;
            disc_addr_d = pcf_q;
          end
        end else if (ack_v) begin
          if (StallF || StallD) begin
            state_d      = S_HOLD;
            hold_instr_d = imem_rdata;
          end else begin
            word_vld = 1'b1;
            pcf_d    = pcf_q + 32'd4;
          end
        end else begin
          pend_d = req;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pcf_d   = redirect_pc;
          state_d = S_REQ;
        end else if (!StallF && !StallD) begin
          word_vld = 1'b1;
          word     = hold_instr_q;
          pcf_d    = pcf_q + 32'd4;
          state_d  = S_REQ;
        end
      end
      S_DISCARD: begin
        if (redirect) pcf_d = redirect_pc;
        if (ack_v) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // IF/ID: flush > stall > new word > bubble. Bubbles keep the old PC fields.
    instr_d_d  = instr_d_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    valid_d_d  = valid_d_q;
    if (FlushD) begin
      instr_d_d = NOP_INSTR;
      valid_d_d = 1'b0;
    end else if (!StallD) begin
      if (word_vld) begin
        instr_d_d  = word;
        pcd_d      = pcf_q;
        pcplus4d_d = pcf_q + 32'd4;
        valid_d_d  = 1'b1;
      end else begin
        instr_d_d = NOP_INSTR;
        valid_d_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      pcf_q        <= RESET_PC & ALIGN_MASK;
      disc_addr_q  <= 32'd0;
      hold_instr_q <= 32'd0;
      pend_q       <= 1'b0;
      instr_d_q    <= NOP_INSTR;
      pcd_q        <= 32'd0;
      pcplus4d_q   <= 32'd0;
      valid_d_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      disc_addr_q  <= disc_addr_d;
      hold_instr_q <= hold_instr_d;
      pend_q       <= pend_d;
      instr_d_q    <= instr_d_d;
      pcd_q        <= pcd_d;
      pcplus4d_q   <= pcplus4d_d;
      valid_d_q    <= valid_d_d;
    end
  end

  assign imem_req   = req;
  assign imem_addr  = addr;
  assign FetchWaitF = req & ~imem_ack;
  assign InstrD     = instr_d_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pcplus4d_q;
  assign ValidD     = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PcSrcE = 1'b0, JalrE = 1'b0;
  logic [31:0] PCTargetE = 32'd0, ALUResultE = 32'd0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchWaitF;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PcSrcE(PcSrcE), .JalrE(JalrE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchWaitF(FetchWaitF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sf, sd, fd, ps, jr;
    logic [31:0] pt, ar;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fw;
    logic [31:0] e_instr, e_pcd, e_pcp4;
    logic        e_valid;
  } vec_t;

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  function automatic vec_t mk(input logic sf, sd, fd, ps, jr,
                              input logic [31:0] pt, ar,
                              input logic ack, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea, input logic efw,
                              input logic [31:0] ei, ep, ep4, input logic ev);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fd = fd; v.ps = ps; v.jr = jr;
    v.pt = pt; v.ar = ar; v.ack = ack; v.rd = rd;
    v.e_req = er; v.e_addr = ea; v.e_fw = efw;
    v.e_instr = ei; v.e_pcd = ep; v.e_pcp4 = ep4; v.e_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    StallF = v.sf; StallD = v.sd; FlushD = v.fd; PcSrcE = v.ps; JalrE = v.jr;
    PCTargetE = v.pt; ALUResultE = v.ar; imem_ack = v.ack; imem_rdata = v.rd;
  endtask

  task automatic idle();
    StallF = 0; StallD = 0; FlushD = 0; PcSrcE = 0; JalrE = 0;
    PCTargetE = 0; ALUResultE = 0; imem_ack = 0; imem_rdata = 0;
  endtask

  vec_t tbl[19];

  initial begin
    //              sf sd fd ps jr pt      ar  ack rd            req addr    fw instr       pcd    pcp4   valid
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,      0,  1, w(0),          1, 0,      0, NOP,        0,     0,     0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0,      0,  1, w(4),          1, 4,      0, w(0),       0,     4,     1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,      0,  1, w(8),          1, 8,      0, w(4),       4,     8,     1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,      0,  1, w(12),         1, 12,     0, w(8),       8,     12,    1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,      0,  0, 0,             1, 16,     1, w(12),      12,    16,    1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,      0,  0, 0,             1, 16,     1, NOP,        12,    16,    0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0,      0,  1, w(16),         1, 16,     0, NOP,        12,    16,    0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0,      0,  0, 0,             0, 16,     0, NOP,        12,    16,    0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0,      0,  1, 32'hDEAD_BEEF, 0, 16,     0, NOP,        12,    16,    0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,      0,  0, 0,             0, 16,     0, NOP,        12,    16,    0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0,      0,  0, 0,             1, 20,     1, w(16),      16,    20,    1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,      0,  1, w(20),         1, 20,     0, NOP,        16,    20,    0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,      0,  1, w(24),         1, 24,     0, w(20),      20,    24,    1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,      0,  1, w(28),         1, 28,     0, w(24),      24,    28,    1);
    tbl[14] = mk(0, 0, 1, 1, 0, 32'h100, 0, 0, 0,             1, 32'h20, 1, w(28),      28,    32,    1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,      0,  0, 0,             1, 32'h20, 1, NOP,        28,    32,    0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0,      0,  1, w(32'h20),     1, 32'h20, 0, NOP,        28,    32,    0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0,      0,  1, w(32'h100),    1, 32'h100,0, NOP,        28,    32,    0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0,      0,  0, 0,             1, 32'h104,1, w(32'h100), 32'h100,32'h104,1);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd",   PCD, 32'd0);
    chk("rst_pcp4",  PCPlus4D, 32'd0);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_req", i),   {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("row%0d_addr", i),  imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_fw", i),    {31'd0, FetchWaitF}, {31'd0, tbl[i].e_fw});
      chk($sformatf("row%0d_instr", i), InstrD, tbl[i].e_instr);
      chk($sformatf("row%0d_pcd", i),   PCD, tbl[i].e_pcd);
      chk($sformatf("row%0d_pcp4", i),  PCPlus4D, tbl[i].e_pcp4);
      chk($sformatf("row%0d_valid", i), {31'd0, ValidD}, {31'd0, tbl[i].e_valid});
    end

    // Jalr and branch together with an ack, FlushD over StallD: jalr target wins, data dropped
    @(negedge clk);
    idle();
    imem_ack = 1; imem_rdata = w(32'h104);
    PcSrcE = 1; JalrE = 1; ALUResultE = 32'h203; PCTargetE = 32'h400; FlushD = 1; StallD = 1;
    #1;
    chk("jalr_req_before",  {31'd0, imem_req}, 32'd1);
    chk("jalr_addr_before", imem_addr, 32'h104);
    @(negedge clk);
    idle();
    #1;
    chk("jalr_addr",  imem_addr, 32'h200);
    chk("jalr_req",   {31'd0, imem_req}, 32'd1);
    chk("jalr_instr", InstrD, NOP);
    chk("jalr_valid", {31'd0, ValidD}, 32'd0);
    chk("jalr_pcd",   PCD, 32'h100);

    // Reset mid-wait: req drops immediately, late ack ignored
    @(negedge clk);
    reset = 1;
    #1;
    chk("midrst_req",   {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, ValidD}, 32'd0);
    chk("midrst_pcd",   PCD, 32'd0);
    @(negedge clk);
    imem_ack = 1; imem_rdata = 32'hBAD0_0000;
    #1;
    chk("midrst_ack_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 0; StallF = 1;
    #1;
    chk("rel_stallf_req",  {31'd0, imem_req}, 32'd0);
    chk("rel_stallf_addr", imem_addr, 32'd0);
    chk("rel_stallf_fw",   {31'd0, FetchWaitF}, 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("rel_req",   {31'd0, imem_req}, 32'd1);
    chk("rel_addr",  imem_addr, 32'd0);
    chk("rel_valid", {31'd0, ValidD}, 32'd0);
    chk("rel_instr", InstrD, NOP);
    chk("rel_fw",    {31'd0, FetchWaitF}, 32'd1);

    // PC wrap with unaligned target: FFFF_FFFF -> FFFF_FFFC, then +4 wraps to 0
    @(negedge clk);
    PcSrcE = 1; PCTargetE = 32'hFFFF_FFFF;
    #1;
    chk("wrap_pend_addr", imem_addr, 32'd0);
    @(negedge clk);
    idle();
    imem_ack = 1; imem_rdata = 32'hBAD0_0001;
    #1;
    chk("wrap_disc_addr", imem_addr, 32'd0);
    chk("wrap_disc_req",  {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    imem_ack = 1; imem_rdata = w(32'hFFFF_FFFC);
    #1;
    chk("wrap_addr",     imem_addr, 32'hFFFF_FFFC);
    chk("wrap_dropped",  {31'd0, ValidD}, 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("wrap_next_addr", imem_addr, 32'd0);
    chk("wrap_instr",     InstrD, w(32'hFFFF_FFFC));
    chk("wrap_pcd",       PCD, 32'hFFFF_FFFC);
    chk("wrap_pcp4",      PCPlus4D, 32'd0);
    chk("wrap_valid",     {31'd0, ValidD}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage and IF/ID pipeline register of the pipelined RV32I core.
- Consumes StallF, StallD, FlushD and the EX-stage redirect (PcSrcE/JalrE) produced by hazard control.
- Owns the PC and a single-outstanding req/ack instruction-memory interface, with a one-entry hold buffer for stalls and discard logic for redirects that hit a pending fetch.
- Delivers InstrD/PCD/PCPlus4D/ValidD to decode.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0013, encoding placed in InstrD for bubbles (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
StallF  in  1  hold PC / do not advance fetch
StallD  in  1  hold IF/ID contents
FlushD  in  1  load bubble into IF/ID
PcSrcE  in  1  branch/jal taken in EX
JalrE  in  1  jalr in EX
PCTargetE  in  32  branch/jal target
ALUResultE  in  32  jalr target (pre-LSB-clear)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, bits[1:0] always 00
imem_ack  in  1  request accepted, imem_rdata valid this cycle
imem_rdata  in  32  instruction word
InstrD  out  32  decode instruction
PCD  out  32  PC of InstrD
PCPlus4D  out  32  PCD+4
ValidD  out  1  InstrD is a real instruction
FetchWaitF  out  1  imem_req & ~imem_ack (for hazard/perf use)

Behaviour:
- Reset (async): PCF=RESET_PC; state=REQ; imem_req=0 while reset is high; InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0; hold buffer empty. First cycle after release: imem_req=1, imem_addr=RESET_PC.
- States: REQ (request PCF), HOLD (word buffered, req=0), DISCARD (req held for stale address, data to be dropped).
- Handshake: one request outstanding. imem_req and imem_addr are stable until the cycle imem_ack=1. Ack can arrive in the first request cycle, giving zero-wait fetch at 1 instr/cycle. imem_ack while imem_req=0 is ignored.
- REQ, ack, no stall (StallF=0, StallD=0): IF/ID <= {rdata, PCF, PCF+4, Valid=1}; PCF <= PCF+4; stay in REQ.
- REQ, ack, StallF|StallD: word and PCF go to the hold buffer; go to HOLD with req=0; PCF is unchanged.
- HOLD: when StallD=0 and StallF=0, IF/ID <= buffer; PCF <= PCF+4; go to REQ (request issued next cycle).
- IF/ID with StallD=0 and no word available (no ack, no buffer): IF/ID <= bubble (InstrD=NOP_INSTR, ValidD=0; PCD/PCPlus4D don't-care but deterministic, hold previous).
- StallD=1, FlushD=0: IF/ID holds.
- FlushD=1 overrides StallD: IF/ID <= bubble.
- Redirect (PcSrcE|JalrE), highest priority:
  - New PC = JalrE ? {ALUResultE[31:2],2'b00} : {PCTargetE[31:2],2'b00}. JalrE wins if both are asserted.
  - Hold buffer is cleared.
  - If ack arrives in the same cycle: data is dropped; PCF <= new PC; state=REQ.
  - If a request is pending without ack: PCF <= new PC; go to DISCARD. imem_req stays high on the old address until ack. That ack's data is dropped. Go to REQ with the new PC on the following cycle.
  - A redirect in DISCARD updates the target again and remains in DISCARD.
  - A redirect in HOLD: PCF <= new PC; state=REQ.
- StallF with no pending request: no new request is issued while StallF=1 (REQ state, req=0). A request already high stays high until ack (handshake rule).
- PC arithmetic is 32-bit modulo. 0xFFFF_FFFC+4 wraps to 0.
- Reset mid-transaction: req drops immediately; an outstanding ack after release is ignored unless a new req is high.

Test Plan:
- Zero-wait memory (ack=req), no hazards, reset released -> imem_addr 0,4,8,12 on consecutive cycles; InstrD follows one cycle later with ValidD=1, PCD=0,4,8.
- Memory with 2-cycle ack latency -> req/addr stable 3 cycles per fetch; intervening IF/ID cycles show NOP_INSTR with ValidD=0; FetchWaitF=1 during wait.
- Ack for PC 0x10 arrives while StallD=1 for 3 cycles -> HOLD, req=0, IF/ID unchanged; stall drops -> InstrD=word@0x10, PCD=0x10, next addr 0x14.
- PcSrcE=1, PCTargetE=0x100 during pending fetch of 0x20 (ack 2 cycles later) -> req held on 0x20, its data dropped, then addr 0x100; InstrD never shows word@0x20.
- JalrE=1 and PcSrcE=1 same cycle, ALUResultE=0x203, PCTargetE=0x400, FlushD=1 with StallD=1 -> next addr 0x200, IF/ID bubble.
- Assert reset mid-wait -> req=0 immediately; after release addr=RESET_PC, a late ack with req=0 is ignored, ValidD=0.
